// File: rtl/legv8_control_sequencer.sv
// rtl/legv8_control_sequencer.sv - multicycle LEGv8 decode/sequence unit
// Accepts one instruction at a time and drives the datapath ControlWord and constant.
module legv8_control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  status,
  output logic [24:0] ControlWord,
  output logic [63:0] constant,
  output logic        done,
  output logic        illegal,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic [63:0] branch_offset
);

  typedef enum logic [1:0] {IDLE, EXEC, LDWB, CBRESP} state_t;
  typedef enum logic [2:0] {K_ILL, K_R, K_SHIFT, K_I, K_LDUR, K_STUR, K_CBZ, K_CBNZ} kind_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  state_t      state;
  logic [31:0] ir;
  logic        zf;
  kind_t       kind;
  logic [4:0]  op_fs;

  logic [4:0]  sa, sb, da, fs;
  logic        reg_write, mem_write, bsel, en_mem, en_alu;
  logic [63:0] dt_ext, br_ext;
  logic        unused_ok;

  assign unused_ok = &{1'b0, status[3:1]};
  assign dt_ext    = {{55{ir[20]}}, ir[20:12]};
  assign br_ext    = {{43{ir[23]}}, ir[23:5], 2'b00};

  // Opcodes are matched longest first: 11-bit, then 10-bit, then 8-bit.
  always_comb begin
    kind  = K_ILL;
    op_fs = FS_AND;
    case (ir[31:21])
      11'b10001011000: begin kind = K_R;     op_fs = FS_ADD; end
      11'b11001011000: begin kind = K_R;     op_fs = FS_SUB; end
      11'b10001010000: begin kind = K_R;     op_fs = FS_AND; end
      11'b10101010000: begin kind = K_R;     op_fs = FS_ORR; end
      11'b11001010000: begin kind = K_R;     op_fs = FS_EOR; end
      11'b11010011011: begin kind = K_SHIFT; op_fs = FS_LSL; end
      11'b11010011010: begin kind = K_SHIFT; op_fs = FS_LSR; end
      11'b11111000010: begin kind = K_LDUR;  op_fs = FS_ADD; end
      11'b11111000000: begin kind = K_STUR;  op_fs = FS_ADD; end
      default: begin
        case (ir[31:22])
          10'b1001000100: begin kind = K_I; op_fs = FS_ADD; end
          10'b1101000100: begin kind = K_I; op_fs = FS_SUB; end
          10'b1001001000: begin kind = K_I; op_fs = FS_AND; end
          10'b1011001000: begin kind = K_I; op_fs = FS_ORR; end
          10'b1101001000: begin kind = K_I; op_fs = FS_EOR; end
          default: begin
            case (ir[31:24])
              8'b10110100: begin kind = K_CBZ;  op_fs = FS_ORR; end
              8'b10110101: begin kind = K_CBNZ; op_fs = FS_ORR; end
              default:     begin kind = K_ILL;  op_fs = FS_AND; end
            endcase
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ir    <= 32'd0;
      zf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (kind)
            K_LDUR: state <= LDWB;
            K_CBZ, K_CBNZ: begin
              zf    <= status[0];
              state <= CBRESP;
            end
            default: state <= IDLE;
          endcase
        end
        LDWB:    state <= IDLE;
        CBRESP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced to zero while reset is high so an aborted instruction commits nothing.
  always_comb begin
    sa            = 5'd0;
    sb            = 5'd0;
    da            = 5'd0;
    fs            = 5'd0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    bsel          = 1'b0;
    en_mem        = 1'b0;
    en_alu        = 1'b0;
    constant      = 64'd0;
    done          = 1'b0;
    illegal       = 1'b0;
    branch_valid  = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 64'd0;
    instr_ready   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: instr_ready = 1'b1;
        EXEC: begin
          fs = op_fs;
          case (kind)
            K_R: begin
              sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0];
              reg_write = 1'b1; en_alu = 1'b1; done = 1'b1;
            end
            K_SHIFT: begin
              sa = ir[9:5]; da = ir[4:0]; bsel = 1'b1;
              reg_write = 1'b1; en_alu = 1'b1; done = 1'b1;
              constant = {58'd0, ir[15:10]};
            end
            K_I: begin
              sa = ir[9:5]; da = ir[4:0]; bsel = 1'b1;
              reg_write = 1'b1; en_alu = 1'b1; done = 1'b1;
              constant = {52'd0, ir[21:10]};
            end
            K_LDUR: begin
              sa = ir[9:5]; da = ir[4:0]; bsel = 1'b1;
              constant = dt_ext;
            end
            K_STUR: begin
              sa = ir[9:5]; sb = ir[4:0]; bsel = 1'b1;
              mem_write = 1'b1; done = 1'b1;
              constant = dt_ext;
            end
            K_CBZ, K_CBNZ: begin
              sa = ir[4:0]; bsel = 1'b1;
            end
            default: begin
              fs = 5'd0; illegal = 1'b1; done = 1'b1;
            end
          endcase
        end
        LDWB: begin
          sa = ir[9:5]; da = ir[4:0]; fs = FS_ADD; bsel = 1'b1;
          reg_write = 1'b1; en_mem = 1'b1; done = 1'b1;
          constant = dt_ext;
        end
        CBRESP: begin
          done          = 1'b1;
          branch_valid  = 1'b1;
          branch_taken  = (kind == K_CBZ) ? zf : !zf;
          branch_offset = br_ext;
        end
        default: ;
      endcase
    end
  end

  assign ControlWord = {sa, sb, da, reg_write, mem_write, fs, bsel, en_mem, en_alu};

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// tb/tb_legv8_control_sequencer.sv - scoreboard bench for legv8_control_sequencer
// Stimulus pushes expected per-cycle responses; a negedge monitor pops and compares.
module tb_legv8_control_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  status;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic        done;
  logic        illegal;
  logic        branch_valid;
  logic        branch_taken;
  logic [63:0] branch_offset;

  legv8_control_sequencer dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status(status), .ControlWord(ControlWord),
    .constant(constant), .done(done), .illegal(illegal), .branch_valid(branch_valid),
    .branch_taken(branch_taken), .branch_offset(branch_offset)
  );

  typedef struct {
    logic [24:0] cw;
    logic [63:0] k;
    logic        d;
    logic        il;
    logic        bv;
    logic        bt;
    logic [63:0] bo;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] cwf(input logic [4:0] sa, input logic [4:0] sb,
      input logic [4:0] da, input logic rw, input logic mw, input logic [4:0] fs,
      input logic bs, input logic em, input logic ea);
    return {sa, sb, da, rw, mw, fs, bs, em, ea};
  endfunction

  task automatic push(input logic [24:0] cw, input logic [63:0] k, input logic d,
      input logic il, input logic bv, input logic bt, input logic [63:0] bo);
    exp_t e;
    e.cw = cw; e.k = k; e.d = d; e.il = il; e.bv = bv; e.bt = bt; e.bo = bo;
    q.push_back(e);
  endtask

  // Monitor: every cycle with visible activity must match the next expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (done || illegal || branch_valid || ControlWord != 25'd0)) begin
        if (q.size() == 0) begin
          chk("unexpected_activity", {39'd0, ControlWord}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("ControlWord", {39'd0, ControlWord}, {39'd0, e.cw});
          chk("constant", constant, e.k);
          chk("done", {63'd0, done}, {63'd0, e.d});
          chk("illegal", {63'd0, illegal}, {63'd0, e.il});
          chk("branch_valid", {63'd0, branch_valid}, {63'd0, e.bv});
          if (e.bv) begin
            chk("branch_taken", {63'd0, branch_taken}, {63'd0, e.bt});
            chk("branch_offset", branch_offset, e.bo);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {63'd0, instr_ready}, 64'd1);
  endtask

  task automatic issue(input logic [31:0] w, input logic [3:0] st);
    wait_ready();
    instr = w; instr_valid = 1'b1; status = st;
    @(posedge clock);
    #1 instr_valid = 1'b0;
  endtask

  logic [31:0] b2b [3];

  initial begin
    reset = 1'b1; instr = 32'd0; instr_valid = 1'b0; status = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {63'd0, instr_ready}, 64'd0);
    chk("rst_cw", {39'd0, ControlWord}, 64'd0);
    chk("rst_const", constant, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("ready_after_rst", {63'd0, instr_ready}, 64'd1);

    // ADD X5,X2,X0
    push(cwf(5'd2, 5'd0, 5'd5, 1, 0, 5'b01000, 0, 0, 1), 64'd0, 1, 0, 0, 0, 0);
    issue(32'h8B000045, 4'd0);
    @(negedge clock); chk("add_exec_ready", {63'd0, instr_ready}, 64'd0);
    @(negedge clock); chk("add_next_ready", {63'd0, instr_ready}, 64'd1);

    // ADDI X1,X0,#4
    push(cwf(5'd0, 5'd0, 5'd1, 1, 0, 5'b01000, 1, 0, 1), 64'd4, 1, 0, 0, 0, 0);
    issue(32'h91001001, 4'd0);
    // LSR X3,X3,#5
    push(cwf(5'd3, 5'd0, 5'd3, 1, 0, 5'b10100, 1, 0, 1), 64'd5, 1, 0, 0, 0, 0);
    issue({11'b11010011010, 5'd0, 6'd5, 5'd3, 5'd3}, 4'd0);
    // LSL X1,X2,#63
    push(cwf(5'd2, 5'd0, 5'd1, 1, 0, 5'b10000, 1, 0, 1), 64'd63, 1, 0, 0, 0, 0);
    issue({11'b11010011011, 5'd0, 6'd63, 5'd2, 5'd1}, 4'd0);
    // SUB X9,X7,X8
    push(cwf(5'd7, 5'd8, 5'd9, 1, 0, 5'b01010, 0, 0, 1), 64'd0, 1, 0, 0, 0, 0);
    issue({11'b11001011000, 5'd8, 6'd0, 5'd7, 5'd9}, 4'd0);
    // ORR X10,X11,X12
    push(cwf(5'd11, 5'd12, 5'd10, 1, 0, 5'b00100, 0, 0, 1), 64'd0, 1, 0, 0, 0, 0);
    issue({11'b10101010000, 5'd12, 6'd0, 5'd11, 5'd10}, 4'd0);
    // EORI X4,X6,#0xABC
    push(cwf(5'd6, 5'd0, 5'd4, 1, 0, 5'b01100, 1, 0, 1), 64'hABC, 1, 0, 0, 0, 0);
    issue({10'b1101001000, 12'hABC, 5'd6, 5'd4}, 4'd0);
    // STUR X1,[X2,#16]
    push(cwf(5'd2, 5'd1, 5'd0, 0, 1, 5'b01000, 1, 0, 0), 64'd16, 1, 0, 0, 0, 0);
    issue({11'b11111000000, 9'd16, 2'b00, 5'd2, 5'd1}, 4'd0);

    // LDUR X2,[X30,#-8]: address cycle then writeback cycle
    push(cwf(5'd30, 5'd0, 5'd2, 0, 0, 5'b01000, 1, 0, 0), NEG8, 0, 0, 0, 0, 0);
    push(cwf(5'd30, 5'd0, 5'd2, 1, 0, 5'b01000, 1, 1, 0), NEG8, 1, 0, 0, 0, 0);
    issue(32'hF85F83C2, 4'd0);
    @(negedge clock); chk("ldur_exec_ready", {63'd0, instr_ready}, 64'd0);
    @(negedge clock); chk("ldur_wb_ready", {63'd0, instr_ready}, 64'd0);
    @(negedge clock); chk("ldur_next_ready", {63'd0, instr_ready}, 64'd1);

    // CBZ X3,#-2 with Z=1
    push(cwf(5'd3, 5'd0, 5'd0, 0, 0, 5'b00100, 1, 0, 0), 64'd0, 0, 0, 0, 0, 0);
    push(25'd0, 64'd0, 1, 0, 1, 1, NEG8);
    issue(32'hB4FFFFC3, 4'b0001);
    // CBNZ X5,#3 with Z=0 then Z=1
    push(cwf(5'd5, 5'd0, 5'd0, 0, 0, 5'b00100, 1, 0, 0), 64'd0, 0, 0, 0, 0, 0);
    push(25'd0, 64'd0, 1, 0, 1, 1, 64'd12);
    issue({8'b10110101, 19'd3, 5'd5}, 4'b0000);
    push(cwf(5'd5, 5'd0, 5'd0, 0, 0, 5'b00100, 1, 0, 0), 64'd0, 0, 0, 0, 0, 0);
    push(25'd0, 64'd0, 1, 0, 1, 0, 64'd12);
    issue({8'b10110101, 19'd3, 5'd5}, 4'b0001);
    // CBZ with Z=0 (not taken)
    push(cwf(5'd3, 5'd0, 5'd0, 0, 0, 5'b00100, 1, 0, 0), 64'd0, 0, 0, 0, 0, 0);
    push(25'd0, 64'd0, 1, 0, 1, 0, NEG8);
    issue(32'hB4FFFFC3, 4'b1110);

    // Illegal word
    push(25'd0, 64'd0, 1, 1, 0, 0, 0);
    issue(32'h00000000, 4'd0);

    // Back-to-back R-type with instr_valid held high: accepted every 2 cycles
    b2b[0] = {11'b10001011000, 5'd1, 6'd0, 5'd2, 5'd3};
    b2b[1] = {11'b10001010000, 5'd4, 6'd0, 5'd5, 5'd6};
    b2b[2] = {11'b11001010000, 5'd7, 6'd0, 5'd8, 5'd9};
    push(cwf(5'd2, 5'd1, 5'd3, 1, 0, 5'b01000, 0, 0, 1), 64'd0, 1, 0, 0, 0, 0);
    push(cwf(5'd5, 5'd4, 5'd6, 1, 0, 5'b00000, 0, 0, 1), 64'd0, 1, 0, 0, 0, 0);
    push(cwf(5'd8, 5'd7, 5'd9, 1, 0, 5'b01100, 0, 0, 1), 64'd0, 1, 0, 0, 0, 0);
    wait_ready();
    @(posedge clock);
    #1 instr = b2b[0]; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); chk("b2b_idle_ready", {63'd0, instr_ready}, 64'd1);
      @(posedge clock);
      #1;
      if (i < 2) instr = b2b[i + 1];
      else instr_valid = 1'b0;
      @(negedge clock); chk("b2b_exec_ready", {63'd0, instr_ready}, 64'd0);
    end

    // Reset during LDUR EXEC aborts the load
    issue(32'hF85F83C2, 4'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_cw", {39'd0, ControlWord}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_const", constant, 64'd0);
    chk("abort_ready", {63'd0, instr_ready}, 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_ready_after", {63'd0, instr_ready}, 64'd1);
    chk("abort_no_wb_done", {63'd0, done}, 64'd0);
    chk("abort_no_wb_cw", {39'd0, ControlWord}, 64'd0);

    repeat (3) @(negedge clock);
    chk("queue_drained", q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
